instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 11 +
 rtl/fetch_buffer.sv | 35 +++
 rtl/instruction_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, reset PC, fetch state encoding and buffer entry type
package instruction_fetch_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} fetch_state_t;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] word;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {word, pc}; entry 0 is always the head
module fetch_buffer import instruction_fetch_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic pop_ok, push_ok, wr;
  assign empty = count == 2'd0;
  assign full = count == 2'd2;
  assign pop_ok = pop & !empty;
  assign push_ok = push & (!full | pop_ok);
  // slot the pushed word lands in once the pop has shifted the queue
  assign wr = count[0] ^ pop_ok;
  assign head = mem[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (pop_ok) mem[0] <= mem[1];
      if (push_ok) mem[wr] <= din;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding-request fetch unit with branch redirect and 2-entry buffer
module instruction_fetch import instruction_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imemReq,
  output logic [31:0]            imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemData,
  input  logic                   branchTaken,
  input  logic [31:0]            branchTarget,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [31:0]            instrPC,
  output logic                   instrValid,
  input  logic                   instrReady
);
  fetch_state_t state, state_n;
  logic [31:0] addr, addr_n, fetch_pc, pc_n, tgt;
  logic push, pop, full, empty;
  logic [1:0] count;
  logic [2:0] occ_push;
  fetch_entry_t entry, head;
  assign tgt = branchTarget & ~32'd3;
  assign pop = instrValid & instrReady;
  assign occ_push = {1'b0, count} + 3'd1 - {2'b0, pop};
  assign entry = '{word: imemData, pc: addr};
  always_comb begin
    state_n = state;
    addr_n = addr;
    pc_n = fetch_pc;
    push = 1'b0;
    case (state)
      IDLE: begin
        state_n = FETCH;
        addr_n = branchTaken ? tgt : addr;
        pc_n = addr_n;
      end
      FETCH: begin
        if (imemAck) begin
          push = !branchTaken;
          pc_n = branchTaken ? tgt : addr + PC_STEP;
          addr_n = pc_n;
          state_n = (branchTaken || occ_push < 3'(BUF_DEPTH)) ? FETCH : HOLD;
        end else if (branchTaken) begin
          state_n = DROP;
          pc_n = tgt;
        end
      end
      HOLD: begin
        state_n = (branchTaken || pop || !full) ? FETCH : HOLD;
        addr_n = branchTaken ? tgt : addr;
        pc_n = addr_n;
      end
      DROP: begin
        // the old address stays on the bus until its response is swallowed
        pc_n = branchTaken ? tgt : fetch_pc;
        state_n = imemAck ? FETCH : DROP;
        addr_n = imemAck ? pc_n : addr;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_n;
      addr <= addr_n;
      fetch_pc <= pc_n;
    end
  fetch_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (branchTaken),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign imemReq = state == FETCH || state == DROP;
  assign imemAddr = addr;
  assign instrValid = !empty;
  assign instruction = head.word;
  assign instrPC = head.pc;
endmodule
